ahb_bus_arbiter: RTL
====================

Name: ahb_bus_arbiter

Overview:
- Shares the single AHB-style data bus (HADDR/HWDATA/HWRITE/HTRANS/HRDATA/HREADY) between two requesters: master 0 = instruction fetch, master 1 = memory-access stage.
- Arbitrates, sequences address and data phases, absorbs slave wait states and returns read data with a done pulse.
- Sits between the pipeline front/back ends and the memory slave. One transfer outstanding at a time.

Parameters:
- STARVE_LIMIT, 4, consecutive master-1 wins allowed while master 0 is waiting before master 0 is forced to win.
- TIMEOUT, 255, data-phase cycles with HREADY low before the transfer is aborted with an error.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held until m0_done or m0_err.
- m0_addr  in  64  master 0 address.
- m0_write  in  1  1 = write, 0 = read.
- m0_wdata  in  64  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: master 0 won arbitration, inputs latched.
- m0_rdata  out  64  read data, valid while m0_done = 1.
- m0_done  out  1  one-cycle completion pulse.
- m0_err  out  1  one-cycle timeout-abort pulse.
- m1_req, m1_addr, m1_write, m1_wdata, m1_gnt, m1_rdata, m1_done, m1_err: same as master 0, for master 1.
- HADDR  out  64  bus address.
- HWRITE  out  1  bus direction.
- HTRANS  out  1  1 = active transfer in address phase.
- HWDATA  out  64  bus write data.
- HRDATA  in  64  bus read data.
- HREADY  in  1  slave ready; completes the data phase.
- busy  out  1  high in ADDR or DATA; the pipeline uses it as a stall source.

Behaviour:
- Reset (async, RST_N = 0): all outputs 0, state IDLE, starvation counter 0, timeout counter 0. Reset asserted mid-transfer drops HTRANS immediately and produces no done or err pulse.
- States:
  - IDLE: when no req is asserted, stay in IDLE. Otherwise, in the same cycle, select the winner, pulse mX_gnt, and latch its addr, write and wdata. Next state ADDR.
  - ADDR: HADDR/HWRITE = latched values, HTRANS = 1, for exactly one cycle. Next state DATA.
  - DATA: HTRANS = 0; HWDATA = latched wdata on writes, 0 on reads.
    - HREADY = 1: capture HRDATA into mX_rdata (reads only; writes leave rdata unchanged), pulse mX_done, go to IDLE.
    - HREADY = 0: increment the timeout counter. If it reaches TIMEOUT, pulse mX_err, go to IDLE, and leave rdata unchanged.
- Minimum latency, req to done: 3 cycles (IDLE→ADDR→DATA with HREADY = 1). A new arbitration can start in the cycle after done, so a back-to-back transfer takes 3 cycles per transfer.
- Arbitration:
  - Master 1 has fixed priority when both request.
  - Starvation counter: increments on each master-1 grant made while m0_req = 1; clears on a master-0 grant, or in any IDLE cycle where m0_req = 0.
  - When the counter = STARVE_LIMIT and both masters request, master 0 wins.
  - Counter saturates at STARVE_LIMIT, with no wrap-around.
- Requests:
  - A requester that drops req before its gnt is simply not served.
  - Changes to req or inputs after gnt are ignored until done or err.
  - The loser of a simultaneous request keeps req high and is served later; no request is lost.
- busy = 1 in ADDR and DATA, 0 in IDLE.
- done and err never assert in the same cycle, and never for both masters in the same cycle.

Decomposition:
- Shared package: state enum (IDLE, ADDR, DATA), master index constants (M_FETCH = 0, M_MEM = 1), HTRANS encoding constants (IDLE = 0, ACTIVE = 1).
- One sub-module: ahb_arb_prio_sel, containing the combinational winner select and the starvation counter. It takes m0_req, m1_req and an arbitrate enable; it outputs a one-hot grant.

Test Plan:
- Single read: m1_req with addr 0x1000, write 0; HREADY = 1 and HRDATA = 0xDEADBEEF in DATA → m1_gnt at cycle 0, HTRANS = 1 with HADDR = 0x1000 at cycle 1, m1_done with m1_rdata = 0xDEADBEEF at cycle 2.
- Write with wait states: m0 write to 0x20 with data 0x55; HREADY low 3 cycles → HWDATA = 0x55 held for 4 DATA cycles, m0_done on the 4th, busy high throughout.
- Contention and starvation: m0_req and m1_req held high continuously, STARVE_LIMIT = 4 → grant order 1,1,1,1,0,1,1,1,1,0.
- Timeout: HREADY held at 0, TIMEOUT = 8 → mX_err pulse after 8 DATA cycles, no done pulse, state returns to IDLE, the next request is served normally.
- Reset mid-transfer: RST_N low during DATA → HTRANS, busy, gnt, done and err all 0 immediately; after release the arbiter idles until a new req arrives.
- Withdrawn request: m0_req pulsed high for one cycle while an m1 transfer is active → no m0_gnt ever issued.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master AHB-style bus arbiter.
package ahb_bus_arbiter_pkg;

  // Transfer sequencing: arbitrate, address phase, data phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Master indices (also bit positions in the one-hot grant vector).
  localparam logic M_FETCH = 1'b0;
  localparam logic M_MEM   = 1'b1;

  // Single-bit HTRANS encoding.
  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;

endpackage

// File: rtl/ahb_arb_prio_sel.sv
// Winner select for the two bus masters. Memory stage (master 1) has fixed
// priority; the fetch master is forced through once master 1 has won
// STARVE_LIMIT times in a row while fetch was waiting.
module ahb_arb_prio_sel
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       arb_en,
  output logic [1:0] gnt
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SW-1:0] starve_q;
  logic          starved;

  assign starved = (starve_q == SW'(STARVE_LIMIT));

  // One-hot grant, only while the arbiter is free to start a transfer.
  always_comb begin
    gnt = 2'b00;
    if (arb_en) begin
      if (m0_req && m1_req) begin
        gnt[M_FETCH] = starved;
        gnt[M_MEM]   = !starved;
      end else if (m1_req) begin
        gnt[M_MEM] = 1'b1;
      end else if (m0_req) begin
        gnt[M_FETCH] = 1'b1;
      end
    end
  end

  // Count master-1 wins that kept fetch waiting; saturates at the limit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_q <= '0;
    end else if (gnt[M_FETCH] || (arb_en && !m0_req)) begin
      starve_q <= '0;
    end else if (gnt[M_MEM] && m0_req && !starved) begin
      starve_q <= starve_q + SW'(1);
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB-style bus between instruction fetch (master 0) and the
// memory stage (master 1). One transfer outstanding at a time:
// IDLE (arbitrate, latch winner) -> ADDR (HTRANS for one cycle) -> DATA
// (wait for HREADY, or abort after TIMEOUT low cycles).
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        m0_req,
  input  logic [63:0] m0_addr,
  input  logic        m0_write,
  input  logic [63:0] m0_wdata,
  output logic        m0_gnt,
  output logic [63:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [63:0] m1_addr,
  input  logic        m1_write,
  input  logic [63:0] m1_wdata,
  output logic        m1_gnt,
  output logic [63:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [63:0] HADDR,
  output logic        HWRITE,
  output logic        HTRANS,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        HREADY,
  output logic        busy
);

  // Down-counter reloaded with TIMEOUT-1 on entering DATA; abort at zero.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state_q;
  logic          owner_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata0_q;
  logic [63:0]   rdata1_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          data_end;
  logic          tmo_end;

  // Gated with reset so no grant can escape while the arbiter is held.
  assign arb_en = (state_q == ST_IDLE) && RST_N;

  ahb_arb_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_sel (
    .CLK   (CLK),
    .RST_N (RST_N),
    .m0_req(m0_req),
    .m1_req(m1_req),
    .arb_en(arb_en),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[M_FETCH];
  assign m1_gnt = gnt[M_MEM];

  assign data_end = (state_q == ST_DATA) && HREADY;
  assign tmo_end  = (state_q == ST_DATA) && !HREADY && (tmo_q == '0);

  assign m0_done = data_end && (owner_q == M_FETCH);
  assign m1_done = data_end && (owner_q == M_MEM);
  assign m0_err  = tmo_end  && (owner_q == M_FETCH);
  assign m1_err  = tmo_end  && (owner_q == M_MEM);

  // Read data is forwarded during the done cycle and held afterwards, so
  // the 3-cycle back-to-back rate needs no extra output stage.
  assign m0_rdata = (m0_done && !HWRITE) ? HRDATA : rdata0_q;
  assign m1_rdata = (m1_done && !HWRITE) ? HRDATA : rdata1_q;

  // Transfer sequencer: latches the winner, drives the bus phases.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      owner_q  <= M_FETCH;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      tmo_q    <= '0;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HTRANS   <= HTRANS_IDLE;
      HWDATA   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt[M_MEM] || gnt[M_FETCH]) begin
            owner_q <= gnt[M_MEM] ? M_MEM : M_FETCH;
            HADDR   <= gnt[M_MEM] ? m1_addr  : m0_addr;
            HWRITE  <= gnt[M_MEM] ? m1_write : m0_write;
            wdata_q <= gnt[M_MEM] ? m1_wdata : m0_wdata;
            HTRANS  <= HTRANS_ACTIVE;
            busy    <= 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          HTRANS  <= HTRANS_IDLE;
          HWDATA  <= HWRITE ? wdata_q : '0;
          tmo_q   <= TW'(TIMEOUT - 1);
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (HREADY) begin
            if (!HWRITE) begin
              if (owner_q == M_MEM) rdata1_q <= HRDATA;
              else                  rdata0_q <= HRDATA;
            end
            HWDATA  <= '0;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmo_q == '0) begin
            HWDATA  <= '0;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
